shift_exec_unit: RTL and testbench



---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 20 ++
 rtl/shift_exec_unit.sv | 94 +++++++++
 tb/tb_shift_exec_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings and widths for the KGP-RISC shift execute unit.
package shift_pkg;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SHLL = 2'b00;
    localparam logic [1:0] OP_SHRL = 2'b01;
    localparam logic [1:0] OP_SHRA = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shift_step.sv
// One-bit shift of the working value; reserved op passes the value through.
module shift_step #(
    parameter int DW = shift_pkg::DATA_W
) (
    input  logic [1:0]    op,
    input  logic [DW-1:0] w,
    output logic [DW-1:0] y
);
    import shift_pkg::*;

    always_comb begin
        y = w;
        case (op)
            OP_SHLL: y = {w[DW-2:0], 1'b0};
            OP_SHRL: y = {1'b0, w[DW-1:1]};
            OP_SHRA: y = {w[DW-1], w[DW-1:1]};
            default: y = w;
        endcase
    end
endmodule

// File: rtl/shift_exec_unit.sv
// Multi-cycle shift execute unit: one bit per clock, single-cycle register write-back.
module shift_exec_unit #(
    parameter int DATA_W  = shift_pkg::DATA_W,
    parameter int ADDR_W  = shift_pkg::ADDR_W,
    parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [ADDR_W-1:0]  dest_addr,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  result,
    output logic               reg_write,
    output logic [ADDR_W-1:0]  write_addr,
    output logic [DATA_W-1:0]  write_data
);
    import shift_pkg::*;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t               state, nextState;
    logic [1:0]           opQ;
    logic [DATA_W-1:0]    workQ, resultQ, stepOut;
    logic [SHAMT_W-1:0]   countQ;
    logic [ADDR_W-1:0]    destQ;
    logic                 errFlag;

    shift_step #(.DW(DATA_W)) uStep (
        .op(opQ),
        .w (workQ),
        .y (stepOut)
    );

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE: begin
                if (start)
                    nextState = (op == OP_RSVD || shamt == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: if (countQ == CNT_ONE) nextState = S_DONE;
            S_DONE:  nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    // resultQ is loaded on entry to DONE so it holds the final value until the next issue
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            opQ     <= OP_SHLL;
            workQ   <= '0;
            resultQ <= '0;
            countQ  <= '0;
            destQ   <= '0;
            errFlag <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opQ     <= op;
                        workQ   <= operand;
                        countQ  <= shamt;
                        destQ   <= dest_addr;
                        errFlag <= (op == OP_RSVD);
                        if (op == OP_RSVD || shamt == '0)
                            resultQ <= operand;
                    end
                end
                S_SHIFT: begin
                    workQ  <= stepOut;
                    countQ <= countQ - CNT_ONE;
                    if (countQ == CNT_ONE)
                        resultQ <= stepOut;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign err        = done && errFlag;
    assign reg_write  = done && !errFlag;
    assign result     = resultQ;
    assign write_data = resultQ;
    assign write_addr = destQ;
endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed-vector bench for shift_exec_unit with hand-computed expected values.
module tb_shift_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [4:0]  destAddr;
    logic        busy, done, err, regWrite;
    logic [31:0] result, writeData;
    logic [4:0]  writeAddr;

    int total = 0;
    int bad = 0;
    int wrCount = 0;

    shift_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand   (operand),
        .shamt     (shamt),
        .dest_addr (destAddr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .reg_write (regWrite),
        .write_addr(writeAddr),
        .write_data(writeData)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (regWrite) wrCount++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble inputs while busy, wait for done and check write-back.
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [4:0] s, input logic [4:0] d, input int expLat,
                         input logic [31:0] expRes, input logic expErr);
        int cyc;
        int w0;
        w0 = wrCount;
        op = o; operand = a; shamt = s; destAddr = d; start = 1'b1;
        tick();
        start = 1'b0; op = 2'b00; operand = 32'hA5A5_A5A5; shamt = 5'd7; destAddr = ~d;
        cyc = 1;
        chk({tag, ".busy1"}, 32'(busy), 32'd1);
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, ".lat"}, cyc, expLat);
        chk({tag, ".result"}, result, expRes);
        chk({tag, ".wdata"}, writeData, expRes);
        chk({tag, ".regwr"}, 32'(regWrite), 32'(!expErr));
        chk({tag, ".err"}, 32'(err), 32'(expErr));
        if (!expErr) chk({tag, ".waddr"}, 32'(writeAddr), 32'(d));
        tick();
        chk({tag, ".doneoff"}, 32'(done), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".hold"}, result, expRes);
        chk({tag, ".wrcnt"}, wrCount - w0, expErr ? 0 : 1);
    endtask

    initial begin
        int w0;
        rst = 1'b1; start = 1'b0; op = 2'b00; operand = '0; shamt = '0; destAddr = '0;
        tick(); tick();
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.regwr", 32'(regWrite), 0);
        chk("rst.result", result, 0);
        chk("rst.waddr", 32'(writeAddr), 0);
        rst = 1'b0;
        tick();

        runOp("shll4",   2'b00, 32'h0000_0001, 5'd4,  5'd7,  5,  32'h0000_0010, 1'b0);
        runOp("shra31",  2'b10, 32'h8000_0000, 5'd31, 5'd3,  32, 32'hFFFF_FFFF, 1'b0);
        runOp("shrl31",  2'b01, 32'h8000_0000, 5'd31, 5'd3,  32, 32'h0000_0001, 1'b0);
        runOp("shrl0",   2'b01, 32'hDEAD_BEEF, 5'd0,  5'd12, 1,  32'hDEAD_BEEF, 1'b0);
        runOp("shra3p",  2'b10, 32'h7000_0000, 5'd3,  5'd31, 4,  32'h0E00_0000, 1'b0);
        runOp("shllcy",  2'b00, 32'h8000_0001, 5'd1,  5'd1,  2,  32'h0000_0002, 1'b0);
        runOp("rsvd",    2'b11, 32'h1234_5678, 5'd9,  5'd5,  1,  32'h1234_5678, 1'b1);

        // start pulses while shifting (cycle 2) and during DONE (cycle 9) are ignored
        w0 = wrCount;
        op = 2'b00; operand = 32'h1; shamt = 5'd8; destAddr = 5'd9; start = 1'b1;
        tick();
        operand = 32'hFFFF_FFFF;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            start = (cyc == 2 || cyc == 9);
            if (cyc == 9) begin
                chk("coll.done", 32'(done), 1);
                chk("coll.result", result, 32'h0000_0100);
            end
            tick();
        end
        start = 1'b0;
        chk("coll.busy10", 32'(busy), 0);
        chk("coll.done10", 32'(done), 0);
        chk("coll.hold", result, 32'h0000_0100);
        tick();
        chk("coll.busy11", 32'(busy), 0);
        chk("coll.wrcnt", wrCount - w0, 1);

        // reset mid-shift abandons the operation with no write-back
        w0 = wrCount;
        op = 2'b01; operand = 32'hF000_0000; shamt = 5'd20; destAddr = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 6; cyc++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst.busy", 32'(busy), 0);
        chk("mrst.done", 32'(done), 0);
        chk("mrst.err", 32'(err), 0);
        chk("mrst.regwr", 32'(regWrite), 0);
        chk("mrst.result", result, 0);
        chk("mrst.wdata", writeData, 0);
        chk("mrst.waddr", 32'(writeAddr), 0);
        for (int cyc = 0; cyc < 25; cyc++) tick();
        chk("mrst.nowr", wrCount - w0, 0);
        chk("mrst.idle", 32'(busy), 0);
        runOp("postrst", 2'b00, 32'h0000_0003, 5'd1, 5'd2, 2, 32'h0000_0006, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
